// File: rtl/equation_generator.sv
// Arithmetic drill generator: issues NUM_EQ LFSR-derived equations per round over a
// valid/ready handshake, with the correct answer precomputed alongside the operands.
module equation_generator #(
   parameter logic [7:0] LFSR_SEED   = 8'hA5,
   parameter int         NUM_EQ      = 3,
   parameter int         MAX_OPERAND = 15
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Abort,
   input  logic [6:0] Seed,
   input  logic       EqReady,
   output logic       EqValid,
   output logic [3:0] OperandA,
   output logic [3:0] OperandB,
   output logic [1:0] OpCode,
   output logic [7:0] Expected,
   output logic [1:0] EqIndex,
   output logic       Busy,
   output logic       RoundDone
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GEN  = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_SUB     = 2'b01;
   localparam logic [1:0] LAST_INDEX = 2'(NUM_EQ - 1);
   localparam logic [4:0] MAX_OP5    = 5'(MAX_OPERAND);
   localparam logic [3:0] WRAP4      = 4'(MAX_OPERAND + 1);

   state_t     state_reg, state_next;
   logic [7:0] lfsr_reg, lfsr_next;
   logic [7:0] lfsr_step, lfsr_mix;
   logic [1:0] eq_index_reg, eq_index_next;
   logic [3:0] op_a_reg, op_b_reg;
   logic [1:0] op_code_reg;
   logic [7:0] expected_reg;

   logic       start_round;
   logic       accept;
   logic       is_last;
   logic       load_eq;

   logic [3:0] raw_nib [2];
   logic [3:0] red_nib [2];
   logic [3:0] gen_a, gen_b;
   logic [1:0] gen_op;
   logic [7:0] gen_exp;

   // ------------------------------------------------------------------
   // LFSR: x^8+x^6+x^5+x^4+1, free-running in every state
   // ------------------------------------------------------------------
   assign lfsr_step   = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
   assign lfsr_mix    = lfsr_step ^ {1'b0, Seed};
   assign start_round = (state_reg == S_IDLE) && Start && !Abort;

   // Mixing in Seed can land on the all-zero lock-up state; fall back to the seed.
   always_comb begin
      lfsr_next = lfsr_step;
      if (start_round) begin
         lfsr_next = (lfsr_mix == 8'd0) ? LFSR_SEED : lfsr_mix;
      end
   end

   // ------------------------------------------------------------------
   // Equation datapath from the current LFSR value
   // ------------------------------------------------------------------
   assign raw_nib[0] = lfsr_reg[3:0];
   assign raw_nib[1] = lfsr_reg[7:4];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_reduce
         assign red_nib[gi] = ({1'b0, raw_nib[gi]} > MAX_OP5) ? (raw_nib[gi] - WRAP4) : raw_nib[gi];
      end
   endgenerate

   // Subtraction is ordered so the answer is never negative.
   always_comb begin
      gen_op = (lfsr_reg[5:4] == 2'b11) ? OP_ADD : lfsr_reg[5:4];
      gen_a  = red_nib[0];
      gen_b  = red_nib[1];
      if ((gen_op == OP_SUB) && (red_nib[0] < red_nib[1])) begin
         gen_a = red_nib[1];
         gen_b = red_nib[0];
      end
      case (gen_op)
         OP_ADD:  gen_exp = {4'd0, gen_a} + {4'd0, gen_b};
         OP_SUB:  gen_exp = {4'd0, gen_a} - {4'd0, gen_b};
         default: gen_exp = {4'd0, gen_a} * {4'd0, gen_b};
      endcase
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   assign accept  = (state_reg == S_HOLD) && EqReady;
   assign is_last = (eq_index_reg == LAST_INDEX);
   assign load_eq = (state_reg == S_GEN) && !Abort;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (Abort) begin
         state_next = S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE:  if (Start) state_next = S_GEN;
            S_GEN:   state_next = S_HOLD;
            S_HOLD:  if (accept) state_next = is_last ? S_DONE : S_GEN;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      EqValid   = 1'b0;
      Busy      = 1'b0;
      RoundDone = 1'b0;
      case (state_reg)
         S_GEN:   Busy = 1'b1;
         S_HOLD:  begin
            Busy    = 1'b1;
            EqValid = 1'b1;
         end
         S_DONE:  begin
            Busy      = 1'b1;
            RoundDone = 1'b1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Index and equation registers
   // ------------------------------------------------------------------
   // EqIndex stays at the last value through DONE so the consumer can still see it.
   always_comb begin
      eq_index_next = eq_index_reg;
      if (Abort) begin
         eq_index_next = 2'd0;
      end else if (accept && !is_last) begin
         eq_index_next = eq_index_reg + 2'd1;
      end else if (state_reg == S_DONE) begin
         eq_index_next = 2'd0;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         lfsr_reg     <= LFSR_SEED;
         eq_index_reg <= 2'd0;
         op_a_reg     <= 4'd0;
         op_b_reg     <= 4'd0;
         op_code_reg  <= 2'd0;
         expected_reg <= 8'd0;
      end else begin
         lfsr_reg     <= lfsr_next;
         eq_index_reg <= eq_index_next;
         if (load_eq) begin
            op_a_reg     <= gen_a;
            op_b_reg     <= gen_b;
            op_code_reg  <= gen_op;
            expected_reg <= gen_exp;
         end
      end
   end

   assign OperandA = op_a_reg;
   assign OperandB = op_b_reg;
   assign OpCode   = op_code_reg;
   assign Expected = expected_reg;
   assign EqIndex  = eq_index_reg;

endmodule

// File: tb/tb_equation_generator.sv
// Directed + randomized bench for equation_generator; a cycle-level LFSR/equation model
// predicts every issued equation from the rules of the block.
module tb_equation_generator;

   localparam int         NUM_EQ = 3;
   localparam int         MAX_OP = 15;
   localparam logic [7:0] SEED0  = 8'hA5;

   logic       Clock   = 1'b0;
   logic       Reset   = 1'b0;
   logic       Start   = 1'b0;
   logic       Abort   = 1'b0;
   logic [6:0] Seed    = 7'd0;
   logic       EqReady = 1'b0;
   logic       EqValid;
   logic [3:0] OperandA;
   logic [3:0] OperandB;
   logic [1:0] OpCode;
   logic [7:0] Expected;
   logic [1:0] EqIndex;
   logic       Busy;
   logic       RoundDone;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] model_lfsr = SEED0;

   equation_generator #(
      .LFSR_SEED   (SEED0),
      .NUM_EQ      (NUM_EQ),
      .MAX_OPERAND (MAX_OP)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .Abort     (Abort),
      .Seed      (Seed),
      .EqReady   (EqReady),
      .EqValid   (EqValid),
      .OperandA  (OperandA),
      .OperandB  (OperandB),
      .OpCode    (OpCode),
      .Expected  (Expected),
      .EqIndex   (EqIndex),
      .Busy      (Busy),
      .RoundDone (RoundDone)
   );

   always #5 Clock = ~Clock;

   initial begin
      #5000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic logic [7:0] mix(input logic [7:0] l, input logic [6:0] s);
      logic [7:0] m;
      m = step(l) ^ {1'b0, s};
      return (m == 8'd0) ? SEED0 : m;
   endfunction

   // {A[3:0], B[3:0], op[1:0], answer[7:0]} derived from an LFSR value with plain arithmetic
   function automatic logic [17:0] equation(input logic [7:0] l);
      int a, b, op, t, res;
      a  = int'(l[3:0]);
      b  = int'(l[7:4]);
      op = int'(l[5:4]);
      if (a > MAX_OP) a = a - (MAX_OP + 1);
      if (b > MAX_OP) b = b - (MAX_OP + 1);
      if (op == 3) op = 0;
      if (op == 1 && a < b) begin
         t = a;
         a = b;
         b = t;
      end
      case (op)
         0:       res = a + b;
         1:       res = a - b;
         default: res = a * b;
      endcase
      return {a[3:0], b[3:0], op[1:0], res[7:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input bit load);
      @(posedge Clock);
      model_lfsr = load ? mix(model_lfsr, Seed) : step(model_lfsr);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, 32'(EqValid), 32'd0);
      check({tag, "_busy"}, 32'(Busy), 32'd0);
      check({tag, "_done"}, 32'(RoundDone), 32'd0);
      check({tag, "_index"}, 32'(EqIndex), 32'd0);
      check({tag, "_a"}, 32'(OperandA), 32'd0);
      check({tag, "_b"}, 32'(OperandB), 32'd0);
      check({tag, "_op"}, 32'(OpCode), 32'd0);
      check({tag, "_exp"}, 32'(Expected), 32'd0);
   endtask

   task automatic check_hold(input int k, input logic [17:0] pred);
      int a, b, r;
      check("hold_valid", 32'(EqValid), 32'd1);
      check("hold_busy", 32'(Busy), 32'd1);
      check("hold_index", 32'(EqIndex), 32'(k));
      check("hold_a", 32'(OperandA), 32'(pred[17:14]));
      check("hold_b", 32'(OperandB), 32'(pred[13:10]));
      check("hold_op", 32'(OpCode), 32'(pred[9:8]));
      check("hold_exp", 32'(Expected), 32'(pred[7:0]));
      a = int'(OperandA);
      b = int'(OperandB);
      r = (OpCode == 2'd0) ? a + b : (OpCode == 2'd1) ? a - b : a * b;
      check("arith", 32'(Expected), 32'(r));
      check("op_legal", 32'(OpCode != 2'd3), 32'd1);
      if (OpCode == 2'd1) check("sub_order", 32'(a >= b), 32'd1);
      check("a_range", 32'(a <= MAX_OP), 32'd1);
      check("b_range", 32'(b <= MAX_OP), 32'd1);
   endtask

   // One full round; stall<0 means random 0..3 backpressure cycles per equation.
   task automatic run_round(input bit tied, input int stall, input bit zero_seed);
      logic [17:0] pred;
      logic [7:0]  nxt;
      int          n, guard;
      EqReady = tied;
      if (zero_seed) begin
         nxt   = step(model_lfsr);
         guard = 0;
         while (nxt[7] && guard < 300) begin
            tick(0);
            nxt = step(model_lfsr);
            guard++;
         end
         Seed = nxt[6:0];
      end else begin
         Seed = 7'($urandom);
      end
      Start = 1'b1;
      tick(1);
      Start = 1'b0;
      check("gen_busy", 32'(Busy), 32'd1);
      check("gen_valid", 32'(EqValid), 32'd0);
      for (int k = 0; k < NUM_EQ; k++) begin
         pred = equation(model_lfsr);
         tick(0);
         check_hold(k, pred);
         if (zero_seed && k == 0) begin
            check("zl_a", 32'(OperandA), 32'd5);
            check("zl_b", 32'(OperandB), 32'd10);
            check("zl_op", 32'(OpCode), 32'd2);
            check("zl_exp", 32'(Expected), 32'd50);
         end
         n = tied ? 0 : ((stall >= 0) ? stall : int'($urandom_range(0, 3)));
         for (int i = 0; i < n; i++) begin
            tick(0);
            check_hold(k, pred);
         end
         EqReady = 1'b1;
         tick(0);
         EqReady = tied;
         if (k < NUM_EQ - 1) begin
            check("acc_valid", 32'(EqValid), 32'd0);
            check("acc_busy", 32'(Busy), 32'd1);
            check("acc_index", 32'(EqIndex), 32'(k + 1));
            check("acc_done", 32'(RoundDone), 32'd0);
         end else begin
            check("done_pulse", 32'(RoundDone), 32'd1);
            check("done_valid", 32'(EqValid), 32'd0);
            check("done_busy", 32'(Busy), 32'd1);
            check("done_index", 32'(EqIndex), 32'(NUM_EQ - 1));
         end
      end
      tick(0);
      check("idle_done", 32'(RoundDone), 32'd0);
      check("idle_busy", 32'(Busy), 32'd0);
      check("idle_index", 32'(EqIndex), 32'd0);
      check("idle_valid", 32'(EqValid), 32'd0);
      check("idle_a_kept", 32'(OperandA), 32'(pred[17:14]));
      EqReady = 1'b0;
   endtask

   initial begin
      logic [17:0] pred;

      // Reset state
      #2;
      check_zero_outputs("reset");
      @(posedge Clock);
      @(posedge Clock);
      #1;
      Reset      = 1'b1;
      model_lfsr = SEED0;
      tick(0);

      // Full round with EqReady tied high
      run_round(1'b1, 0, 1'b0);

      // Backpressure: 20 stalled cycles on every equation
      run_round(1'b0, 20, 1'b0);

      // Zero-lock seed
      run_round(1'b0, -1, 1'b1);

      // Abort in HOLD at EqIndex=1
      Seed  = 7'($urandom);
      Start = 1'b1;
      tick(1);
      Start = 1'b0;
      pred  = equation(model_lfsr);
      tick(0);
      check_hold(0, pred);
      EqReady = 1'b1;
      tick(0);
      EqReady = 1'b0;
      pred    = equation(model_lfsr);
      tick(0);
      check_hold(1, pred);
      Abort = 1'b1;
      tick(0);
      Abort = 1'b0;
      check("abort_valid", 32'(EqValid), 32'd0);
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_index", 32'(EqIndex), 32'd0);
      check("abort_done", 32'(RoundDone), 32'd0);
      check("abort_a_kept", 32'(OperandA), 32'(pred[17:14]));
      tick(0);
      check("abort_done2", 32'(RoundDone), 32'd0);
      check("abort_busy2", 32'(Busy), 32'd0);

      // Start held high through a whole round restarts from IDLE
      EqReady = 1'b1;
      Seed    = 7'($urandom);
      Start   = 1'b1;
      tick(1);
      for (int k = 0; k < NUM_EQ; k++) begin
         pred = equation(model_lfsr);
         tick(0);
         check_hold(k, pred);
         tick(0);
      end
      check("held_done", 32'(RoundDone), 32'd1);
      tick(0);
      check("held_idle_busy", 32'(Busy), 32'd0);
      check("held_idle_done", 32'(RoundDone), 32'd0);
      tick(1);
      check("held_restart_busy", 32'(Busy), 32'd1);
      check("held_restart_valid", 32'(EqValid), 32'd0);
      pred = equation(model_lfsr);
      tick(0);
      check_hold(0, pred);
      Start   = 1'b0;
      EqReady = 1'b0;
      Abort   = 1'b1;
      tick(0);
      Abort = 1'b0;
      check("held_abort_busy", 32'(Busy), 32'd0);

      // Randomized rounds
      for (int r = 0; r < 1000; r++) begin
         run_round(1'b0, -1, 1'b0);
      end

      // Asynchronous reset asserted in the middle of GEN
      Seed  = 7'($urandom);
      Start = 1'b1;
      tick(1);
      Start = 1'b0;
      check("pre_reset_busy", 32'(Busy), 32'd1);
      #2;
      Reset = 1'b0;
      #1;
      check_zero_outputs("async_reset");
      @(posedge Clock);
      #1;
      check_zero_outputs("reset_held");
      Reset      = 1'b1;
      model_lfsr = SEED0;
      tick(0);
      run_round(1'b0, -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
